mix_columns_iter: RTL and testbench

//  Sequential, parametrised successor to the combinational AES MixColumns stage.
//  - Accepts one 128-bit AES state over a valid/ready handshake.
//  - Transforms COLS_PER_CYCLE columns per clock.
//  - Presents the result on a held valid/ready output.
//  - Sits between ShiftRows and AddRoundKey in the iterative round datapath.
//  - Supports InvMixColumns when compiled in, so encrypt and decrypt share one block.

---
 rtl/mix_columns_iter.sv | 178 +++++++++++++++++
 tb/tb_mix_columns_iter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mix_columns_iter: iterative AES (Inv)MixColumns, COLS_PER_CYCLE cols/clk |
// | Define MIXCOL_INV_EN to build in the inverse network. Rev 1.0            |
// +--------------------------------------------------------------------------+
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         inv_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int BUSY_CYCLES = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] c_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] c_LAST = 2'((BUSY_CYCLES - 1) * COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_work;
  logic [127:0] w_work_nxt;
  logic [1:0]   r_col_idx;
  logic         w_accept;
  logic         w_last;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1B & {8{x[7]}});
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] i);
    logic [31:0] col;
    case (i)
      2'd0:    col = s[127:96];
      2'd1:    col = s[95:64];
      2'd2:    col = s[63:32];
      default: col = s[31:0];
    endcase
    return col;
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0]  a [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) a[r] = col[31-8*r -: 8];
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return res;
  endfunction

`ifdef MIXCOL_INV_EN
  logic r_inv;

  // 9/B/D/E built from the x2, x4, x8 doublings of each byte.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0]  a  [4];
    logic [7:0]  m9 [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  me [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xt(a[r]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction
`else
  logic w_unused_inv;
  assign w_unused_inv = inv_in;
`endif

  logic [1:0]  w_lane_idx [COLS_PER_CYCLE];
  logic [31:0] w_lane_in  [COLS_PER_CYCLE];
  logic [31:0] w_lane_out [COLS_PER_CYCLE];

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
    assign w_lane_idx[j] = r_col_idx + 2'(j);
    assign w_lane_in[j]  = get_col(r_work, w_lane_idx[j]);
`ifdef MIXCOL_INV_EN
    assign w_lane_out[j] = r_inv ? mix_inv(w_lane_in[j]) : mix_fwd(w_lane_in[j]);
`else
    assign w_lane_out[j] = mix_fwd(w_lane_in[j]);
`endif
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
        if (w_lane_idx[j] == 2'(c)) w_work_nxt[127-32*c -: 32] = w_lane_out[j];
      end
    end
  end

  assign w_last   = (r_col_idx == c_LAST);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // in_ready must never look at in_valid, so it is decoded from state and out_ready only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready    = 1'b1;
          w_state_nxt = in_valid ? S_BUSY : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_col_idx <= '0;
`ifdef MIXCOL_INV_EN
      r_inv     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_work    <= state_in;
      r_col_idx <= '0;
`ifdef MIXCOL_INV_EN
      r_inv     <= inv_in;
`endif
    end else if (r_state == S_BUSY) begin
      r_work    <= w_work_nxt;
      r_col_idx <= r_col_idx + c_STEP;
    end
  end

  assign state_out = r_work;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// Testbench for mix_columns_iter: directed FIPS vectors plus random states
// checked against a generic GF(2^8) matrix-multiply model.
module tb_mix_columns_iter;

  parameter int CPC = 4;
  localparam int B = 4 / CPC;
`ifdef MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int n_assert = 0;
  int n_fail   = 0;

  mix_columns_iter #(.COLS_PER_CYCLE(CPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .inv_in    (inv_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[k], s[127-32*c-8*((r+k)%4) -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a state and let it be accepted on the next edge.
  task automatic start(input logic [127:0] s, input logic inv);
    state_in = s;
    inv_in   = inv;
    in_valid = 1'b1;
    #1;
    chk("accept_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    state_in = rnd128();
    inv_in   = ~inv;
  endtask

  // Walk through the BUSY cycles with junk on the input, then check the result.
  task automatic wait_result(input string tag, input logic [127:0] exp);
    for (int k = 1; k <= B; k++) begin
      in_valid = 1'b1;
      state_in = rnd128();
      inv_in   = ~inv_in;
      #1;
      chk("busy_ready", 128'(in_ready), 128'd0);
      chk("busy_valid", 128'(out_valid), 128'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("done_valid", 128'(out_valid), 128'd1);
    chk(tag, state_out, exp);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    #1;
    chk("done_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_valid", 128'(out_valid), 128'd0);
  endtask

  logic [127:0] s1, s2, e1;
  logic         inv1, inv2;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    state_in  = '0;
    inv_in    = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_ready", 128'(in_ready), 128'd1);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_out", state_out, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // FIPS-197 forward columns.
    start(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0);
    wait_result("fips_fwd", 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    release_out();

`ifdef MIXCOL_INV_EN
    start(128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, 1'b1);
    wait_result("fips_inv", 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5);
    release_out();
`else
    start(128'hdb135345_f20a225c_01010101_2d26314c, 1'b1);
    wait_result("inv_ignored", 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    release_out();
`endif

    for (int i = 0; i < 6; i++) begin
      s1   = rnd128();
      inv1 = 1'($urandom_range(0, 1));
      start(s1, inv1);
      wait_result("rand", ref_mix(s1, inv1 & INV_EN));
      release_out();
    end

    // Backpressure in DONE, then a back-to-back accept.
    s1   = rnd128();
    inv1 = 1'($urandom_range(0, 1));
    e1   = ref_mix(s1, inv1 & INV_EN);
    start(s1, inv1);
    wait_result("bp_first", e1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 128'(out_valid), 128'd1);
      chk("bp_hold", state_out, e1);
      chk("bp_ready", 128'(in_ready), 128'd0);
    end
    s2   = rnd128();
    inv2 = ~inv1;
    out_ready = 1'b1;
    start(s2, inv2);
    out_ready = 1'b0;
    wait_result("b2b_second", ref_mix(s2, inv2 & INV_EN));
    release_out();

    // Asynchronous reset in the middle of a transform.
    start(rnd128(), 1'b0);
    if (B >= 2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_out", state_out, 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 128'(out_valid), 128'd0);
    s1 = rnd128();
    start(s1, 1'b1);
    wait_result("post_rst", ref_mix(s1, INV_EN));
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
